// File: rtl/raster_scan_counter.sv
// 2-D column/row walker over a runtime WxH frame with line/frame-end and kernel-border flags.
// col/row and done/cfg_err are registered, the flags are combinational; a low en_count_i holds the position.
module raster_scan_counter #(
    parameter int MAX_COLS = 640,
    parameter int MAX_ROWS = 480,
    parameter int KSIZE    = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic                          restart_i,
    input  logic                          en_count_i,
    input  logic [$clog2(MAX_COLS+1)-1:0] cfg_cols_i,
    input  logic [$clog2(MAX_ROWS+1)-1:0] cfg_rows_i,
    output logic [$clog2(MAX_COLS)-1:0]   col_o,
    output logic [$clog2(MAX_ROWS)-1:0]   row_o,
    output logic                          busy_o,
    output logic                          line_end_o,
    output logic                          frame_end_o,
    output logic                          border_o,
    output logic                          done_o,
    output logic                          cfg_err_o
);

    localparam int CW   = $clog2(MAX_COLS+1);
    localparam int RW   = $clog2(MAX_ROWS+1);
    localparam int COLW = $clog2(MAX_COLS);
    localparam int ROWW = $clog2(MAX_ROWS);
    localparam int HALF = KSIZE / 2;
    localparam int BW   = ((CW > RW) ? CW : RW) + 2;

    localparam logic [BW-1:0] HALF_W = BW'(HALF);
    localparam logic [BW-1:0] ONE_W  = BW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [COLW-1:0]   col_q, col_d;
    logic [ROWW-1:0]   row_q, row_d;
    logic [CW-1:0]     cols_q, cols_d;
    logic [RW-1:0]     rows_q, rows_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              busy;
    logic              cfg_ok;
    logic [BW-1:0]     col_w, row_w, cols_w, rows_w;
    logic              last_col, last_row;

    // Widened copies so "size-1" and "size-1-HALF" never wrap for tiny frames.
    assign col_w  = BW'(col_q);
    assign row_w  = BW'(row_q);
    assign cols_w = BW'(cols_q);
    assign rows_w = BW'(rows_q);

    assign busy     = (state_q == RUN);
    assign last_col = (col_w + ONE_W) == cols_w;
    assign last_row = (row_w + ONE_W) == rows_w;

    assign cfg_ok = (cfg_cols_i >= CW'(2)) && (cfg_cols_i <= CW'(MAX_COLS)) &&
                    (cfg_rows_i >= RW'(2)) && (cfg_rows_i <= RW'(MAX_ROWS));

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cols_d  = cols_q;
        rows_d  = rows_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (restart_i) begin
            state_d = IDLE;
            col_d   = '0;
            row_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    col_d = '0;
                    row_d = '0;
                    if (start_i) begin
                        if (cfg_ok) begin
                            cols_d  = cfg_cols_i;
                            rows_d  = cfg_rows_i;
                            state_d = RUN;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (en_count_i) begin
                        if (last_col && last_row) begin
                            col_d   = '0;
                            row_d   = '0;
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else if (last_col) begin
                            col_d = '0;
                            row_d = row_q + ROWW'(1);
                        end else begin
                            col_d = col_q + COLW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    col_d   = '0;
                    row_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            cols_q  <= '0;
            rows_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cols_q  <= cols_d;
            rows_q  <= rows_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign col_o       = col_q;
    assign row_o       = row_q;
    assign busy_o      = busy;
    assign line_end_o  = busy & last_col;
    assign frame_end_o = busy & last_col & last_row;
    // col > cols-1-HALF is rewritten as col+HALF >= cols to stay underflow-free.
    assign border_o    = busy & ((col_w < HALF_W) || ((col_w + HALF_W) >= cols_w) ||
                                 (row_w < HALF_W) || ((row_w + HALF_W) >= rows_w));
    assign done_o      = done_q;
    assign cfg_err_o   = err_q;

endmodule

// File: tb/tb_raster_scan_counter.sv
// Randomised and directed checks of raster_scan_counter against a pixel-index reference model.
module tb_raster_scan_counter;

    localparam int MAXC = 640;
    localparam int MAXR = 480;
    localparam int K    = 3;
    localparam int HALF = K / 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0, restart_i = 1'b0, en_count_i = 1'b0;
    logic [9:0]  cfg_cols_i = '0;
    logic [8:0]  cfg_rows_i = '0;
    logic [9:0]  col_o;
    logic [8:0]  row_o;
    logic        busy_o, line_end_o, frame_end_o, border_o, done_o, cfg_err_o;

    raster_scan_counter #(.MAX_COLS(MAXC), .MAX_ROWS(MAXR), .KSIZE(K)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .restart_i(restart_i),
        .en_count_i(en_count_i), .cfg_cols_i(cfg_cols_i), .cfg_rows_i(cfg_rows_i),
        .col_o(col_o), .row_o(row_o), .busy_o(busy_o), .line_end_o(line_end_o),
        .frame_end_o(frame_end_o), .border_o(border_o), .done_o(done_o),
        .cfg_err_o(cfg_err_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_inner = 0;

    // Reference: a frame is just a pixel index p in [0, W*H); col/row follow from it.
    bit m_busy = 0, m_done = 0, m_err = 0;
    int m_w = 0, m_h = 0, m_p = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int c, r;
        bit le, fe, bd;
        c  = m_busy ? (m_p % m_w) : 0;
        r  = m_busy ? (m_p / m_w) : 0;
        le = m_busy && (c == m_w - 1);
        fe = le && (r == m_h - 1);
        bd = m_busy && (c < HALF || c > m_w - 1 - HALF || r < HALF || r > m_h - 1 - HALF);
        chk("col", 32'(col_o), 32'(c));
        chk("row", 32'(row_o), 32'(r));
        chk("busy", 32'(busy_o), 32'(m_busy));
        chk("line_end", 32'(line_end_o), 32'(le));
        chk("frame_end", 32'(frame_end_o), 32'(fe));
        chk("border", 32'(border_o), 32'(bd));
        chk("done", 32'(done_o), 32'(m_done));
        chk("cfg_err", 32'(cfg_err_o), 32'(m_err));
        if (done_o === 1'b1) n_done++;
        if (busy_o === 1'b1 && border_o === 1'b0) n_inner++;
    endtask

    task automatic model_step();
        int w, h;
        w = int'(cfg_cols_i);
        h = int'(cfg_rows_i);
        m_done = 0;
        m_err  = 0;
        if (restart_i) begin
            m_busy = 0;
            m_p    = 0;
        end else if (!m_busy) begin
            if (start_i) begin
                if (w >= 2 && w <= MAXC && h >= 2 && h <= MAXR) begin
                    m_w = w; m_h = h; m_p = 0; m_busy = 1;
                end else begin
                    m_err = 1;
                end
            end
        end else if (en_count_i) begin
            if (m_p == m_w * m_h - 1) begin
                m_busy = 0; m_p = 0; m_done = 1;
            end else begin
                m_p++;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int w, input int h);
        start_i = 1'b1;
        cfg_cols_i = 10'(w);
        cfg_rows_i = 9'(h);
        cycle();
        start_i = 1'b0;
    endtask

    task automatic run_en(input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            en_count_i = toggle ? ((i % 2) == 0) : 1'b1;
            cycle();
        end
        en_count_i = 1'b0;
    endtask

    initial begin
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();

        // Asynchronous reset in the middle of a frame at (5,2).
        start_frame(8, 4);
        run_en(21, 0);
        chk("pre_rst_col", 32'(col_o), 32'd5);
        chk("pre_rst_row", 32'(row_o), 32'd2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_col", 32'(col_o), 32'd0);
        chk("rst_row", 32'(row_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_flags", 32'({line_end_o, frame_end_o, border_o, done_o, cfg_err_o}), 32'd0);
        m_busy = 0; m_p = 0; m_w = 0; m_h = 0; m_done = 0; m_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();

        // 4x3 with en held, then toggled.
        n_done = 0;
        start_frame(4, 3);
        run_en(14, 0);
        chk("done_once_held", 32'(n_done), 32'd1);
        n_done = 0;
        start_frame(4, 3);
        run_en(25, 1);
        cycle();
        chk("done_once_toggled", 32'(n_done), 32'd1);

        // Rejected and boundary configurations.
        start_frame(1, 2);
        start_frame(2, 0);
        start_frame(MAXC + 1, 2);
        start_frame(2, MAXR + 1);
        cycle();
        start_frame(2, 2);
        run_en(5, 0);
        start_frame(MAXC, MAXR);
        run_en(3, 0);
        restart_i = 1'b1;
        cycle();
        restart_i = 1'b0;

        // Border interior counts.
        n_inner = 0;
        start_frame(5, 4);
        run_en(21, 0);
        chk("inner_5x4", 32'(n_inner), 32'd6);
        n_inner = 0;
        start_frame(2, 2);
        run_en(5, 0);
        chk("inner_2x2", 32'(n_inner), 32'd0);

        // Restart mid-frame, restart+start together, start while busy.
        n_done = 0;
        start_frame(4, 3);
        run_en(6, 0);
        restart_i = 1'b1;
        cycle();
        restart_i = 1'b0;
        cycle();
        restart_i = 1'b1;
        start_frame(3, 3);
        restart_i = 1'b0;
        cycle();
        chk("restart_no_done", 32'(n_done), 32'd0);
        start_frame(4, 3);
        run_en(3, 0);
        start_frame(2, 2);
        run_en(10, 0);
        cycle();
        chk("busy_start_ignored_done", 32'(n_done), 32'd1);

        // Random traffic, including back-to-back starts in the done cycle.
        for (int i = 0; i < 4000; i++) begin
            int sel;
            restart_i  = ($urandom_range(0, 99) == 0);
            start_i    = ($urandom_range(0, 4) == 0);
            en_count_i = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 9);
            if (sel < 8) begin
                cfg_cols_i = 10'($urandom_range(2, 7));
                cfg_rows_i = 9'($urandom_range(2, 6));
            end else begin
                case ($urandom_range(0, 4))
                    0: cfg_cols_i = 10'd0;
                    1: cfg_cols_i = 10'd1;
                    2: cfg_cols_i = 10'(MAXC + 1);
                    3: cfg_cols_i = 10'(MAXC);
                    default: cfg_cols_i = 10'd1023;
                endcase
                cfg_rows_i = 9'($urandom_range(0, MAXR + 2));
            end
            cycle();
        end
        restart_i = 1'b0;
        start_i = 1'b0;
        en_count_i = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
